// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the RV32I datapath and a handshaked data bus.
// Bus outputs are registered for the whole REQ phase; load data is extracted from latched offset/size.
module lsu_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ls_req,
    input  logic        i_ls_we,
    input  logic [1:0]  i_d_size,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_ls_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);
    state_t      r_state, w_next;
    logic [7:0]  r_wait_cnt;
    logic        r_err, r_live, r_uns;
    logic [1:0]  r_off, r_size;
    logic        w_bad, w_timeout, w_live;
    logic [3:0]  w_be;
    logic [31:0] w_bwd, w_shift, w_ext;
    assign w_bad     = (&i_d_size) | (i_d_size == 2'b01 & i_addr[0]) | (i_d_size == 2'b00 & |i_addr[1:0]);
    assign w_timeout = r_wait_cnt == LP_LAST;
    // a request dropped mid-transaction still finishes on the bus but its result is thrown away
    assign w_live    = r_live & i_ls_req;
    assign w_be      = i_d_size == 2'b10 ? 4'b0001 << i_addr[1:0] :
                       i_d_size == 2'b01 ? 4'b0011 << i_addr[1:0] : 4'b1111;
    assign w_bwd     = i_d_size == 2'b10 ? {4{i_wdata[7:0]}} :
                       i_d_size == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
    assign w_shift   = i_bus_rdata >> {r_off, 3'b000};
    assign w_ext     = r_size == 2'b10 ? {{24{~r_uns & w_shift[7]}}, w_shift[7:0]} :
                       r_size == 2'b01 ? {{16{~r_uns & w_shift[15]}}, w_shift[15:0]} : w_shift;
    assign o_stall   = (r_state == S_IDLE & i_ls_req) | (r_state == S_REQ);
    assign o_ls_err  = (r_state == S_DONE) & r_err;
    always_comb begin
        w_next = S_IDLE;
        if (r_state == S_IDLE)
            w_next = i_ls_req ? (w_bad ? S_DONE : S_REQ) : S_IDLE;
        else if (r_state == S_REQ)
            w_next = (i_bus_ack | w_timeout) ? S_DONE : S_REQ;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_live      <= 1'b0;
            r_uns       <= 1'b0;
            r_off       <= '0;
            r_size      <= '0;
            o_rdata     <= '0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_be    <= '0;
            o_bus_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_ls_req) begin
                    r_err <= w_bad;
                    if (!w_bad) begin
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_ls_we;
                        o_bus_addr  <= {i_addr[31:2], 2'b00};
                        o_bus_be    <= w_be;
                        o_bus_wdata <= w_bwd;
                        r_off       <= i_addr[1:0];
                        r_size      <= i_d_size;
                        r_uns       <= i_ld_unsigned;
                        r_wait_cnt  <= '0;
                        r_live      <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (!i_ls_req) r_live <= 1'b0;
                    if (i_bus_ack | w_timeout) begin
                        o_bus_req   <= 1'b0;
                        o_bus_we    <= 1'b0;
                        o_bus_addr  <= '0;
                        o_bus_be    <= '0;
                        o_bus_wdata <= '0;
                        r_err       <= ~i_bus_ack & w_live;
                        if (i_bus_ack & w_live & ~o_bus_we) o_rdata <= w_ext;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: r_err <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed-vector bench for lsu_ctrl with hand-computed expectations.
module tb_lsu_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ls_req = 1'b0, ls_we = 1'b0, ld_uns = 1'b0, bus_ack = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic        stall, ls_err, bus_req, bus_we;
    logic [3:0]  bus_be;
    int          n_chk = 0, n_fail = 0;

    lsu_ctrl #(.MAX_WAIT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ls_req(ls_req), .i_ls_we(ls_we),
        .i_d_size(d_size), .i_ld_unsigned(ld_uns), .i_addr(addr), .i_wdata(wdata),
        .o_rdata(rdata), .o_stall(stall), .o_ls_err(ls_err), .o_bus_req(bus_req),
        .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_be(bus_be),
        .o_bus_wdata(bus_wdata), .i_bus_rdata(bus_rdata), .i_bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one access from IDLE; k = REQ cycle in which ack is given (0 = never).
    task automatic access(input logic [1:0] sz, input logic we, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int k, input logic [3:0] e_be, input logic [31:0] e_wd,
                          input logic [31:0] e_rd, input int e_stall, input int e_req,
                          input logic e_err);
        int ns = 0, nr = 0;
        ls_req = 1'b1; ls_we = we; d_size = sz; ld_uns = uns;
        addr = a; wdata = wd; bus_rdata = rd;
        #1;
        while (stall && ns < 40) begin
            ns++;
            if (bus_req) begin
                nr++;
                chk("bus_addr", bus_addr, {a[31:2], 2'b00});
                chk("bus_be", {28'd0, bus_be}, {28'd0, e_be});
                chk("bus_wdata", bus_wdata, e_wd);
                chk("bus_we", {31'd0, bus_we}, {31'd0, we});
            end
            bus_ack = bus_req && (nr == k);
            step();
        end
        bus_ack = 1'b0;
        chk("stall_cycles", ns, e_stall);
        chk("req_cycles", nr, e_req);
        chk("ls_err_done", {31'd0, ls_err}, {31'd0, e_err});
        chk("rdata_done", rdata, e_rd);
        chk("bus_req_done", {31'd0, bus_req}, 32'd0);
        ls_req = 1'b0;
        step();
        chk("ls_err_after", {31'd0, ls_err}, 32'd0);
        chk("stall_after", {31'd0, stall}, 32'd0);
    endtask

    initial begin
        step();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        rst_n = 1'b1;
        step();
        // size, we, uns, addr, wdata, bus_rdata, k, be, bus_wdata, rdata, stall, req, err
        access(2'b00, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 4'b1111, 32'h0, 32'hDEADBEEF, 2, 1, 0);
        access(2'b10, 0, 0, 32'h103, 32'h0, 32'h80FF1234, 1, 4'b1000, 32'h0, 32'hFFFFFF80, 2, 1, 0);
        access(2'b10, 0, 1, 32'h103, 32'h0, 32'h80FF1234, 1, 4'b1000, 32'h0, 32'h00000080, 2, 1, 0);
        access(2'b01, 1, 0, 32'h22, 32'h0000ABCD, 32'h0, 3, 4'b1100, 32'hABCDABCD, 32'h80, 4, 3, 0);
        access(2'b10, 1, 0, 32'h11, 32'h1234565A, 32'h0, 2, 4'b0010, 32'h5A5A5A5A, 32'h80, 3, 2, 0);
        access(2'b00, 1, 0, 32'h101, 32'h11111111, 32'h0, 1, 4'b0000, 32'h0, 32'h80, 1, 0, 1);
        access(2'b11, 0, 0, 32'h40, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 32'h80, 1, 0, 1);
        access(2'b00, 0, 0, 32'h200, 32'h0, 32'hCAFEF00D, 0, 4'b1111, 32'h0, 32'h80, 5, 4, 1);
        access(2'b01, 0, 0, 32'h102, 32'h0, 32'h80010000, 1, 4'b1100, 32'h0, 32'hFFFF8001, 2, 1, 0);
        ls_req = 1'b1; ls_we = 1'b0; d_size = 2'b00; addr = 32'h300; bus_rdata = 32'h55AA55AA;
        step();
        step();
        chk("mid_req_bus_req", {31'd0, bus_req}, 32'd1);
        rst_n = 1'b0; ls_req = 1'b0; bus_ack = 1'b1;
        #1;
        chk("mr_bus_req", {31'd0, bus_req}, 32'd0);
        chk("mr_bus_addr", bus_addr, 32'd0);
        chk("mr_bus_be", {28'd0, bus_be}, 32'd0);
        chk("mr_rdata", rdata, 32'd0);
        chk("mr_stall", {31'd0, stall}, 32'd0);
        chk("mr_ls_err", {31'd0, ls_err}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("post_rst_rdata", rdata, 32'd0);
        bus_ack = 1'b0;
        access(2'b00, 0, 0, 32'h0, 32'h0, 32'h12345678, 2, 4'b1111, 32'h0, 32'h12345678, 3, 2, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
